dual_port_ram_ctrl: RTL and testbench
=====================================

Name: dual_port_ram_ctrl

Overview:
- Initiator-side controller for the 64x8 dual-port RAM block. It drives the RAM's two ports: per-port data, address, write enable, and registered read data.
- Turns two independent valid/ready request streams into legal RAM port cycles, tags read responses, stalls port B on same-address conflicts, and zero-fills the RAM after reset.
- Sits between the client logic and the RAM instance.

Parameters:
- DATA_W, 8, data width of each port; must match the RAM word width.
- ADDR_W, 6, address width; depth = 2**ADDR_W; must be at least 1.
- INIT_VAL, 0, DATA_W-bit value written to every location during initialisation.

Ports:
- clk  in  1  single clock, rising edge; also drives the RAM instance.
- rst_n  in  1  asynchronous active-low reset.
- req_a_valid  in  1  port A request present.
- req_a_ready  out  1  port A request accepted this cycle.
- req_a_we  in  1  1 = write, 0 = read.
- req_a_addr  in  ADDR_W  port A address.
- req_a_wdata  in  DATA_W  port A write data.
- rsp_a_valid  out  1  port A read data valid.
- rsp_a_rdata  out  DATA_W  port A read data.
- req_b_valid, req_b_ready, req_b_we, req_b_addr, req_b_wdata, rsp_b_valid, rsp_b_rdata: same as port A, for port B.
- ram_data_a, ram_data_b  out  DATA_W  to RAM data inputs.
- ram_addr_a, ram_addr_b  out  ADDR_W  to RAM addresses.
- ram_we_a, ram_we_b  out  1  to RAM write enables.
- ram_q_a, ram_q_b  in  DATA_W  from RAM registered outputs.
- init_done  out  1  high once initialisation completes.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, named rst_n.
- Reset values:
  - state = INIT, init_addr = 0.
  - init_done = 0, rsp_a_valid = 0, rsp_b_valid = 0.
  - req_a_ready = 0, req_b_ready = 0.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle, port A writes INIT_VAL to address 2*k and port B writes INIT_VAL to address 2*k+1, with k = init_addr.
  - Both ram_we are 1; both req_ready are 0.
  - When k reaches depth/2-1, on that edge move to RUN and set init_done = 1.
  - With depth 64 this takes 32 cycles.
  - If depth = 2**ADDR_W is 1, port A writes address 0, port B is idle, and INIT lasts 1 cycle.
- RUN, ready rules:
  - req_a_ready = 1.
  - req_b_ready = 0 only when conflict = req_a_valid & req_b_valid & (req_a_addr == req_b_addr) & (req_a_we | req_b_we). Otherwise req_b_ready = 1.
  - Port A always wins a conflict. B holds its request and is accepted the next cycle unless it conflicts again.
  - Two reads to the same address never conflict.
- RUN, RAM drive:
  - An accepted request (valid & ready) drives ram_addr = req_addr, ram_data = req_wdata, ram_we = req_we.
  - With no accepted request, ram_we = 0 and ram_addr/ram_data hold their previous values.
  - The RAM drive path is combinational from the request.
- Read latency is 1 cycle:
  - An accepted read at edge N sets rsp_x_valid high for the cycle after edge N.
  - rsp_x_rdata = ram_q_x, passed straight through.
  - rsp_x_valid is 0 after an accepted write or an idle cycle.
  - No backpressure on responses.
- Write-then-read to the same address on the next cycle, either port: the read returns the new data.
- Reset mid-operation: any rst_n low returns to INIT, clears the response valids, and restarts the fill from address 0. An in-flight read response is dropped.

Optional Feature:
- Macro: DPRAM_CTRL_COLLISION_CNT_EN.
- When defined:
  - Adds output port collision_cnt [15:0].
  - The counter increments on every RUN cycle where conflict = 1, saturates at 16'hFFFF, and resets to 0.
  - It is not cleared by leaving INIT.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release → ram_we_a/b high for exactly 32 cycles on addresses 0,2..62 / 1,3..63 with data 0; init_done rises after the 32nd edge; both ready = 0 throughout.
- After init, A reads address 17 → rsp_a_valid = 1 one cycle later, rsp_a_rdata = 8'h00.
- A writes 8'hA5 to address 5; next cycle B reads address 5 → rsp_b_rdata = 8'hA5, no stall.
- Same cycle: A writes 8'h11 and B writes 8'h22, both to address 9 → req_b_ready = 0 for 1 cycle, B accepted the following cycle; a subsequent read of address 9 returns 8'h22; collision_cnt = 1 when the macro is defined.
- Same cycle: A and B both read address 40 → both ready = 1, both rsp_valid next cycle with equal data.
- Assert rst_n low at INIT cycle 10 → outputs return to reset values immediately; the fill restarts at address 0 and completes 32 cycles after release.

Source files
------------

// File: rtl/dual_port_ram_ctrl.sv
// Initiator-side controller for a 64x8 dual-port RAM: zero-fill after reset, then
// two valid/ready request streams with port-A priority on same-address conflicts.
// Optional: `define DPRAM_CTRL_COLLISION_CNT_EN adds a saturating conflict counter.
module dual_port_ram_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a_valid,
  output logic              req_a_ready,
  input  logic              req_a_we,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [DATA_W-1:0] req_a_wdata,
  output logic              rsp_a_valid,
  output logic [DATA_W-1:0] rsp_a_rdata,
  input  logic              req_b_valid,
  output logic              req_b_ready,
  input  logic              req_b_we,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [DATA_W-1:0] req_b_wdata,
  output logic              rsp_b_valid,
  output logic [DATA_W-1:0] rsp_b_rdata,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_a,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic              init_done
`ifdef DPRAM_CTRL_COLLISION_CNT_EN
  , output logic [15:0]     collision_cnt
`endif
);

  // Fill walks word pairs, so the init counter is one bit narrower than the address.
  localparam int            IW        = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam logic [IW-1:0] INIT_LAST = IW'((2 ** ADDR_W) / 2 - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q;
  logic [IW-1:0]       init_q;
  logic                init_done_q, rsp_a_vld_q, rsp_b_vld_q;
  logic [ADDR_W-1:0]   addr_a_q, addr_b_q, addr_a_d, addr_b_d;
  logic [DATA_W-1:0]   data_a_q, data_b_q, data_a_d, data_b_d;
  logic                we_a_d, we_b_d;
  logic                run, conflict, acc_a, acc_b;

  assign run      = (state_q == S_RUN);
  assign conflict = req_a_valid & req_b_valid & (req_a_addr == req_b_addr) &
                    (req_a_we | req_b_we);

  assign req_a_ready = run;
  assign req_b_ready = run & ~conflict;
  assign acc_a       = req_a_valid & req_a_ready;
  assign acc_b       = req_b_valid & req_b_ready;

  always_comb begin
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
    we_a_d   = 1'b0;
    we_b_d   = 1'b0;
    if (!run) begin
      addr_a_d = ADDR_W'({init_q, 1'b0});
      addr_b_d = ADDR_W'({init_q, 1'b1});
      data_a_d = INIT_VAL;
      data_b_d = INIT_VAL;
      we_a_d   = 1'b1;
      we_b_d   = 1'b1;
    end else begin
      if (acc_a) begin
        addr_a_d = req_a_addr;
        data_a_d = req_a_wdata;
        we_a_d   = req_a_we;
      end
      if (acc_b) begin
        addr_b_d = req_b_addr;
        data_b_d = req_b_wdata;
        we_b_d   = req_b_we;
      end
    end
  end

  assign ram_addr_a  = addr_a_d;
  assign ram_addr_b  = addr_b_d;
  assign ram_data_a  = data_a_d;
  assign ram_data_b  = data_b_d;
  assign ram_we_a    = we_a_d;
  assign ram_we_b    = we_b_d;
  assign rsp_a_valid = rsp_a_vld_q;
  assign rsp_b_valid = rsp_b_vld_q;
  assign rsp_a_rdata = ram_q_a;
  assign rsp_b_rdata = ram_q_b;
  assign init_done   = init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_q      <= '0;
      init_done_q <= 1'b0;
      rsp_a_vld_q <= 1'b0;
      rsp_b_vld_q <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
    end else begin
      // Remember the last drive so an idle cycle holds the RAM address/data steady.
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      case (state_q)
        S_INIT: begin
          rsp_a_vld_q <= 1'b0;
          rsp_b_vld_q <= 1'b0;
          init_q      <= init_q + 1'b1;
          if (init_q == INIT_LAST) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          rsp_a_vld_q <= acc_a & ~req_a_we;
          rsp_b_vld_q <= acc_b & ~req_b_we;
        end
      endcase
    end
  end

`ifdef DPRAM_CTRL_COLLISION_CNT_EN
  logic [15:0] coll_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          coll_q <= '0;
    else if (run && conflict && coll_q != 16'hFFFF) coll_q <= coll_q + 16'd1;
  end

  assign collision_cnt = coll_q;
`endif

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Random + directed bench for dual_port_ram_ctrl against a memory-array reference
// model, with a behavioural 64x8 registered-output RAM attached to the RAM ports.
module tb_dual_port_ram_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_a_valid, req_a_ready, req_a_we, rsp_a_valid;
  logic       req_b_valid, req_b_ready, req_b_we, rsp_b_valid;
  logic [5:0] req_a_addr, req_b_addr, ram_addr_a, ram_addr_b;
  logic [7:0] req_a_wdata, req_b_wdata, rsp_a_rdata, rsp_b_rdata;
  logic [7:0] ram_data_a, ram_data_b, ram_q_a, ram_q_b;
  logic       ram_we_a, ram_we_b, init_done;
`ifdef DPRAM_CTRL_COLLISION_CNT_EN
  logic [15:0] collision_cnt;
`endif

  dual_port_ram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_valid(req_a_valid), .req_a_ready(req_a_ready), .req_a_we(req_a_we),
    .req_a_addr(req_a_addr), .req_a_wdata(req_a_wdata),
    .rsp_a_valid(rsp_a_valid), .rsp_a_rdata(rsp_a_rdata),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_we(req_b_we),
    .req_b_addr(req_b_addr), .req_b_wdata(req_b_wdata),
    .rsp_b_valid(rsp_b_valid), .rsp_b_rdata(rsp_b_rdata),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
    .init_done(init_done)
`ifdef DPRAM_CTRL_COLLISION_CNT_EN
    , .collision_cnt(collision_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM contents start as non-zero garbage so the fill is observable.
  logic [7:0] mem [64] = '{default: 8'hFF};
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  int          n_vec = 0, n_err = 0;
  logic [7:0]  ref_mem [64];
  logic        exp_va, exp_vb;
  logic [7:0]  exp_da, exp_db;
  int unsigned cnt_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    exp_va = 1'b0; exp_vb = 1'b0; exp_da = '0; exp_db = '0; cnt_m = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {init_done, req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid,
              ram_we_a, ram_we_b, ram_addr_a, ram_addr_b},
        {5'b0, 2'b11, 6'd0, 6'd1});
  endtask

  // Entered at a negedge just after reset release; leaves at the negedge after the 32nd edge.
  task automatic fill_check();
    for (int k = 0; k < 32; k++) begin
      chk("init_drv", {ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_data_a, ram_data_b},
          {2'b11, 6'(2*k), 6'(2*k+1), 16'h0000});
      chk("init_hs", {init_done, req_a_ready, req_b_ready, rsp_a_valid, rsp_b_valid}, 32'd0);
      @(negedge clk);
    end
    chk("init_done", {init_done, req_a_ready}, 2'b11);
  endtask

  // Called just after a posedge; applies one cycle of requests and checks everything.
  task automatic step(input logic av, input logic awe, input logic [5:0] aa, input logic [7:0] ad,
                      input logic bv, input logic bwe, input logic [5:0] ba, input logic [7:0] bd,
                      output logic b_stall);
    logic conf, accb;
    req_a_valid = av; req_a_we = awe; req_a_addr = aa; req_a_wdata = ad;
    req_b_valid = bv; req_b_we = bwe; req_b_addr = ba; req_b_wdata = bd;
    @(negedge clk);
    conf = av & bv & (aa == ba) & (awe | bwe);
    accb = bv & ~conf;
    chk("rsp_a_v", rsp_a_valid, exp_va);
    if (exp_va) chk("rsp_a_d", rsp_a_rdata, exp_da);
    chk("rsp_b_v", rsp_b_valid, exp_vb);
    if (exp_vb) chk("rsp_b_d", rsp_b_rdata, exp_db);
    chk("ready", {req_a_ready, req_b_ready}, {1'b1, ~conf});
    chk("ram_we", {ram_we_a, ram_we_b}, {av & awe, accb & bwe});
    if (av)   chk("ram_a", {ram_addr_a, ram_data_a}, {aa, ad});
    if (accb) chk("ram_b", {ram_addr_b, ram_data_b}, {ba, bd});
`ifdef DPRAM_CTRL_COLLISION_CNT_EN
    chk("coll_cnt", collision_cnt, cnt_m);
`endif
    exp_va = av & ~awe;   exp_da = ref_mem[aa];
    exp_vb = accb & ~bwe; exp_db = ref_mem[ba];
    if (av & awe)   ref_mem[aa] = ad;
    if (accb & bwe) ref_mem[ba] = bd;
    if (conf && cnt_m < 65535) cnt_m++;
    b_stall = bv & conf;
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
  endfunction

  initial begin
    logic       st, bv, bwe;
    logic [5:0] ba;
    logic [7:0] bd;
    req_a_valid = 0; req_a_we = 0; req_a_addr = '0; req_a_wdata = '0;
    req_b_valid = 0; req_b_we = 0; req_b_addr = '0; req_b_wdata = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("init_cyc10", {ram_addr_a, ram_addr_b}, {6'd20, 6'd21});
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset_mid_init");
    @(negedge clk);
    rst_n = 1'b1;
    fill_check();
    @(posedge clk); #1;

    step(1, 0, 17, 8'h00, 0, 0, 0, 8'h00, st);
    step(1, 1, 5, 8'hA5, 0, 0, 0, 8'h00, st);
    step(0, 0, 0, 8'h00, 1, 0, 5, 8'h00, st);
    step(1, 1, 9, 8'h11, 1, 1, 9, 8'h22, st);
    step(0, 0, 0, 8'h00, 1, 1, 9, 8'h22, st);
    step(1, 0, 9, 8'h00, 0, 0, 0, 8'h00, st);
    step(1, 0, 40, 8'h00, 1, 0, 40, 8'h00, st);
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, st);

    st = 1'b0; bv = 0; bwe = 0; ba = '0; bd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!st) begin
        bv = ($urandom_range(0, 3) != 0); bwe = $urandom_range(0, 1);
        ba = rnd_addr(); bd = 8'($urandom);
      end
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom),
           bv, bwe, ba, bd, st);
    end
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, st);

    // Reset with a read response in flight drops it.
    step(1, 0, 3, 8'h00, 0, 0, 0, 8'h00, st);
    rst_n = 1'b0;
    #1 chk_reset_vals("reset_in_run");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    fill_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
